// File: rtl/gshare_history_unit.sv
// Gshare global-history manager: speculative/architectural GHR, PHT index hashing,
// registered PHT write port, and a power-up sweep that initialises every PHT entry.
module gshare_history_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int GHR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid_i,
    input  logic [31:0]           pred_pc_i,
    input  logic                  pred_taken_i,
    output logic [ADDR_WIDTH-1:0] pred_rindex_o,
    output logic [GHR_WIDTH-1:0]  pred_ghr_o,
    input  logic                  resolve_valid_i,
    output logic                  resolve_ready_o,
    input  logic [31:0]           resolve_pc_i,
    input  logic [GHR_WIDTH-1:0]  resolve_ghr_i,
    input  logic [1:0]            resolve_phr_i,
    input  logic                  resolve_taken_i,
    input  logic                  resolve_mispredict_i,
    input  logic                  flush_i,
    output logic                  pht_we_o,
    output logic [ADDR_WIDTH-1:0] pht_windex_o,
    output logic                  pht_taken_o,
    output logic [1:0]            pht_phr_o
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = {ADDR_WIDTH{1'b1}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   sweep_cnt_r;
    logic [GHR_WIDTH-1:0]    spec_ghr_r;
    logic [GHR_WIDTH-1:0]    arch_ghr_r;
    logic [GHR_WIDTH-1:0]    arch_ghr_next_s;
    logic [GHR_WIDTH-1:0]    spec_ghr_next_s;
    logic                    resolve_accept_s;
    logic                    unused_s;

    // Gshare hash: word-aligned PC bits XOR zero-extended history.
    function automatic logic [ADDR_WIDTH-1:0] hash_index(
        input logic [ADDR_WIDTH-1:0] pc_bits,
        input logic [GHR_WIDTH-1:0]  ghr
    );
        hash_index = pc_bits ^ ADDR_WIDTH'(ghr);
    endfunction

    assign unused_s = ^{pred_pc_i[31:ADDR_WIDTH+2], pred_pc_i[1:0],
                        resolve_pc_i[31:ADDR_WIDTH+2], resolve_pc_i[1:0],
                        resolve_ghr_i[GHR_WIDTH-1]};

    assign resolve_accept_s = resolve_valid_i & resolve_ready_o;
    assign pred_rindex_o    = hash_index(pred_pc_i[ADDR_WIDTH+1:2], spec_ghr_r);
    assign pred_ghr_o       = spec_ghr_r;

    // Next architectural history: shift in the actual outcome of an accepted resolve.
    always_comb begin
        arch_ghr_next_s = arch_ghr_r;
        if (resolve_accept_s) begin
            arch_ghr_next_s = {arch_ghr_r[GHR_WIDTH-2:0], resolve_taken_i};
        end else begin
            arch_ghr_next_s = arch_ghr_r;
        end
    end

    // Next speculative history; flush and mispredict repair override a same-cycle prediction.
    always_comb begin
        spec_ghr_next_s = spec_ghr_r;
        if (flush_i) begin
            spec_ghr_next_s = arch_ghr_next_s;
        end else if (resolve_accept_s && resolve_mispredict_i) begin
            spec_ghr_next_s = {resolve_ghr_i[GHR_WIDTH-2:0], resolve_taken_i};
        end else if (pred_valid_i) begin
            spec_ghr_next_s = {spec_ghr_r[GHR_WIDTH-2:0], pred_taken_i};
        end else begin
            spec_ghr_next_s = spec_ghr_r;
        end
    end

    // History registers run in both states; the sweep does not gate them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr_r <= {GHR_WIDTH{1'b0}};
            arch_ghr_r <= {GHR_WIDTH{1'b0}};
        end else begin
            spec_ghr_r <= spec_ghr_next_s;
            arch_ghr_r <= arch_ghr_next_s;
        end
    end

    // Init sweep / run FSM with registered PHT write port; ready follows RUN by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_INIT;
            sweep_cnt_r     <= {ADDR_WIDTH{1'b0}};
            resolve_ready_o <= 1'b0;
            pht_we_o        <= 1'b0;
            pht_windex_o    <= {ADDR_WIDTH{1'b0}};
            pht_taken_o     <= 1'b0;
            pht_phr_o       <= 2'b00;
        end else begin
            resolve_ready_o <= (state_r == ST_RUN);
            case (state_r)
                ST_INIT: begin
                    pht_we_o     <= 1'b1;
                    pht_windex_o <= sweep_cnt_r;
                    pht_taken_o  <= 1'b1;
                    pht_phr_o    <= 2'b00;
                    if (sweep_cnt_r == SWEEP_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        sweep_cnt_r <= sweep_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    pht_we_o <= resolve_accept_s;
                    if (resolve_accept_s) begin
                        pht_windex_o <= hash_index(resolve_pc_i[ADDR_WIDTH+1:2], resolve_ghr_i);
                        pht_taken_o  <= resolve_taken_i;
                        pht_phr_o    <= resolve_phr_i;
                    end else begin
                        pht_windex_o <= pht_windex_o;
                    end
                end
                default: begin
                    state_r  <= ST_INIT;
                    pht_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_history_unit.sv
// Scoreboard bench for gshare_history_unit: stimulus pushes expected prediction
// and PHT-write records; a negedge monitor pops and compares them.
module tb_gshare_history_unit;

    localparam int AW = 8;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid_i;
    logic [31:0]   pred_pc_i;
    logic          pred_taken_i;
    logic [AW-1:0] pred_rindex_o;
    logic [GW-1:0] pred_ghr_o;
    logic          resolve_valid_i;
    logic          resolve_ready_o;
    logic [31:0]   resolve_pc_i;
    logic [GW-1:0] resolve_ghr_i;
    logic [1:0]    resolve_phr_i;
    logic          resolve_taken_i;
    logic          resolve_mispredict_i;
    logic          flush_i;
    logic          pht_we_o;
    logic [AW-1:0] pht_windex_o;
    logic          pht_taken_o;
    logic [1:0]    pht_phr_o;

    logic [10:0] wr_q[$];
    logic [15:0] pr_q[$];
    int errors = 0;
    int checks = 0;

    gshare_history_unit #(.ADDR_WIDTH(AW), .GHR_WIDTH(GW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i),
        .pred_rindex_o(pred_rindex_o), .pred_ghr_o(pred_ghr_o),
        .resolve_valid_i(resolve_valid_i), .resolve_ready_o(resolve_ready_o),
        .resolve_pc_i(resolve_pc_i), .resolve_ghr_i(resolve_ghr_i),
        .resolve_phr_i(resolve_phr_i), .resolve_taken_i(resolve_taken_i),
        .resolve_mispredict_i(resolve_mispredict_i), .flush_i(flush_i),
        .pht_we_o(pht_we_o), .pht_windex_o(pht_windex_o),
        .pht_taken_o(pht_taken_o), .pht_phr_o(pht_phr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented prediction or PHT write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pred_valid_i) begin
                if (pr_q.size() == 0) begin
                    check("pred_unexpected", 32'd1, 32'd0);
                end else begin
                    check("pred_rindex_ghr", {16'd0, pred_rindex_o, pred_ghr_o}, {16'd0, pr_q.pop_front()});
                end
            end
            if (pht_we_o) begin
                if (wr_q.size() == 0) begin
                    check("pht_write_unexpected", {21'd0, pht_windex_o, pht_taken_o, pht_phr_o}, 32'hFFFF_FFFF);
                end else begin
                    check("pht_write", {21'd0, pht_windex_o, pht_taken_o, pht_phr_o}, {21'd0, wr_q.pop_front()});
                end
            end
        end
    end

    task automatic idle();
        pred_valid_i = 1'b0; pred_pc_i = 32'd0; pred_taken_i = 1'b0;
        resolve_valid_i = 1'b0; resolve_pc_i = 32'd0; resolve_ghr_i = 8'd0;
        resolve_phr_i = 2'b00; resolve_taken_i = 1'b0; resolve_mispredict_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pred(input logic [31:0] pc, input logic tk, input logic [7:0] e_idx, input logic [7:0] e_ghr);
        pred_valid_i = 1'b1; pred_pc_i = pc; pred_taken_i = tk;
        pr_q.push_back({e_idx, e_ghr});
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [7:0] ghr, input logic [1:0] phr,
                           input logic tk, input logic mis, input logic [7:0] e_idx);
        resolve_valid_i = 1'b1; resolve_pc_i = pc; resolve_ghr_i = ghr;
        resolve_phr_i = phr; resolve_taken_i = tk; resolve_mispredict_i = mis;
        wr_q.push_back({e_idx, tk, phr});
    endtask

    // Releases reset at a falling edge and checks the full 256-entry sweep and ready timing.
    task automatic release_and_sweep(input bit poke_resolve);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) wr_q.push_back({i[7:0], 1'b1, 2'b00});
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            check("ready_low_in_init", {31'd0, resolve_ready_o}, 32'd0);
            idle();
            if (poke_resolve && k < 4) begin
                resolve_valid_i = 1'b1; resolve_mispredict_i = 1'b1;
                resolve_taken_i = 1'b1; resolve_ghr_i = 8'hAA; resolve_pc_i = 32'h3C;
            end
        end
        @(posedge clk);
        #1;
        check("ready_after_sweep", {31'd0, resolve_ready_o}, 32'd1);
        idle();
    endtask

    initial begin
        logic [7:0] tk_bits;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", {31'd0, pht_we_o}, 32'd0);
        check("rst_windex", {24'd0, pht_windex_o}, 32'd0);
        check("rst_taken_phr", {29'd0, pht_taken_o, pht_phr_o}, 32'd0);
        check("rst_ready", {31'd0, resolve_ready_o}, 32'd0);
        check("rst_ghr", {24'd0, pred_ghr_o}, 32'd0);

        release_and_sweep(1'b1);

        // Speculative shifts and hashing
        pred(32'h40, 1'b1, 8'h10, 8'h00); cyc();
        pred(32'h40, 1'b0, 8'h11, 8'h01); cyc();
        pred(32'h44, 1'b1, 8'h13, 8'h02); cyc();
        // Plain resolve: one registered write then we drops
        resolve(32'h80, 8'h03, 2'b10, 1'b1, 1'b0, 8'h23); cyc();
        cyc();
        check("we_drop", {31'd0, pht_we_o}, 32'd0);
        // Mispredict repair beats same-cycle prediction
        resolve(32'h100, 8'h05, 2'b01, 1'b0, 1'b1, 8'h45);
        pred(32'h40, 1'b1, 8'h15, 8'h05); cyc();
        pred(32'h0, 1'b0, 8'h0A, 8'h0A); cyc();
        // Back-to-back resolves to one index, each with its own phr; arch goes 0x02 -> 0x0F
        tk_bits = 8'b0000_1111;
        for (int i = 0; i < 8; i++) begin
            resolve(32'h0C, 8'h00, 2'(i), tk_bits[7-i], 1'b0, 8'h03); cyc();
        end
        // Flush with same-cycle accepted mispredict resolve: flush wins
        flush_i = 1'b1;
        resolve(32'h0, 8'h33, 2'b11, 1'b1, 1'b1, 8'h33); cyc();
        pred(32'h0, 1'b0, 8'h1F, 8'h1F); cyc();
        flush_i = 1'b1;
        pred(32'h0, 1'b1, 8'h3E, 8'h3E); cyc();
        pred(32'h0, 1'b0, 8'h1F, 8'h1F); cyc();
        pred(32'hFFFF_F3FC, 1'b0, 8'hC1, 8'h3E); cyc();
        repeat (2) cyc();
        check("queues_drained_run", wr_q.size() + pr_q.size(), 32'd0);

        // Reset mid-RUN, then again mid-sweep at index 0x80
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_run_ready", {31'd0, resolve_ready_o}, 32'd0);
        check("rst_run_ghr", {24'd0, pred_ghr_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 8'h80; i++) wr_q.push_back({i[7:0], 1'b1, 2'b00});
        repeat (129) @(posedge clk);
        #1;
        check("sweep_at_80", {24'd0, pht_windex_o}, 32'h80);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, pht_we_o}, 32'd0);
        check("rst_mid_windex", {24'd0, pht_windex_o}, 32'd0);
        check("queue_at_mid_reset", wr_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        release_and_sweep(1'b0);
        repeat (3) cyc();
        check("queues_drained_end", wr_q.size() + pr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_history_unit.md
GSHARE_HISTORY_UNIT -- requirements
Module: gshare_history_unit

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 8 and set the PHT index width (table depth 2**ADDR_WIDTH).
REQ-002 The parameter GHR_WIDTH SHALL default to 8, set the global history length, and SHALL satisfy GHR_WIDTH <= ADDR_WIDTH.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and be the asynchronous, active-low reset.
REQ-005 The port pred_valid_i SHALL be an input, 1 bit wide, and mark a branch prediction request this cycle.
REQ-006 The port pred_pc_i SHALL be an input, 32 bits wide, and carry the branch PC.
REQ-007 The port pred_taken_i SHALL be an input, 1 bit wide, and carry the predicted direction to shift into speculative history.
REQ-008 The port pred_rindex_o SHALL be an output, ADDR_WIDTH bits wide, and carry the PHT read index.
REQ-009 The port pred_ghr_o SHALL be an output, GHR_WIDTH bits wide, and carry the speculative GHR used for this prediction (the snapshot carried with the branch).
REQ-010 The port resolve_valid_i SHALL be an input, 1 bit wide, and mark a resolved branch.
REQ-011 The port resolve_ready_o SHALL be an output, 1 bit wide; 0 during INIT, 1 in RUN.
REQ-012 The port resolve_pc_i SHALL be an input, 32 bits wide, and carry the resolved branch PC.
REQ-013 The port resolve_ghr_i SHALL be an input, GHR_WIDTH bits wide, and carry the GHR snapshot taken at prediction.
REQ-014 The port resolve_phr_i SHALL be an input, 2 bits wide, and carry the counter value read at prediction.
REQ-015 The port resolve_taken_i SHALL be an input, 1 bit wide, and carry the actual direction.
REQ-016 The port resolve_mispredict_i SHALL be an input, 1 bit wide, and mark that the direction was mispredicted.
REQ-017 The port flush_i SHALL be an input, 1 bit wide, and request a pipeline flush that restores the architectural GHR.
REQ-018 The ports pht_we_o, pht_windex_o, pht_taken_o and pht_phr_o SHALL be outputs, 1, ADDR_WIDTH, 1 and 2 bits wide respectively, and drive the PHT write port (we, windex, taken, phr).

Function
REQ-019 The output pred_rindex_o SHALL equal pred_pc_i[ADDR_WIDTH+1:2] XOR zero-extended spec_ghr (combinational), and pred_ghr_o SHALL equal spec_ghr.
REQ-020 A resolve SHALL be accepted iff resolve_valid_i && resolve_ready_o; unaccepted resolves have no effect.
REQ-021 On an accepted resolve, arch_ghr SHALL become {arch_ghr[GHR_WIDTH-2:0], resolve_taken_i}.
REQ-022 spec_ghr next-state priority SHALL be: flush_i -> next arch_ghr (including a same-cycle accepted resolve); else accepted mispredict -> {resolve_ghr_i[GHR_WIDTH-2:0], resolve_taken_i}; else pred_valid_i -> {spec_ghr[GHR_WIDTH-2:0], pred_taken_i}; else hold.
REQ-023 A prediction in the same cycle as a mispredict or flush SHALL be discarded for history purposes.
REQ-024 An accepted resolve at edge N SHALL produce, in the cycle after edge N: pht_we_o=1; pht_windex_o = resolve_pc_i[ADDR_WIDTH+1:2] XOR zero-extended resolve_ghr_i; pht_taken_o=resolve_taken_i; pht_phr_o=resolve_phr_i; all registered.
REQ-025 In RUN, pht_we_o SHALL be 0 in any cycle not preceded by an accepted resolve; the write fields SHALL hold their last values.
REQ-026 The FSM SHALL have two states: INIT (entered on reset) and RUN.
REQ-027 In INIT, a counter of ADDR_WIDTH bits SHALL sweep from 0 to 2**ADDR_WIDTH-1, one index per cycle, driving pht_we_o=1, pht_windex_o=counter, pht_phr_o=2'b00 and pht_taken_o=1 (writes weakly-not-taken 2'b01).
REQ-028 After the write of index 2**ADDR_WIDTH-1, the FSM SHALL enter RUN; INIT SHALL last exactly 2**ADDR_WIDTH cycles; the counter SHALL not wrap into a second sweep.
REQ-029 Predictions, GHR shifts and flush SHALL operate normally during INIT; flush_i SHALL NOT abort or restart the sweep.
REQ-030 Repeated resolves to the same index SHALL each issue a write using their own resolve_phr_i; no merging.

Reset
REQ-031 While rst_n=0: spec_ghr=0, arch_ghr=0, state=INIT, sweep counter=0, resolve_ready_o=0, pht_we_o=0, pht_windex_o=0, pht_taken_o=0, pht_phr_o=0.
REQ-032 Reset asserted mid-sweep or mid-RUN SHALL return to INIT and restart the sweep from index 0 after release.

Verification
REQ-033 Release reset, ADDR_WIDTH=8 -> 256 consecutive cycles with pht_we_o=1, windex 0x00..0xFF, phr=00, taken=1; resolve_ready_o rises the cycle after windex=0xFF.
REQ-034 RUN, spec_ghr=0x00, pred pc=0x40, taken=1 -> rindex=0x10, pred_ghr_o=0x00; next cycle pc=0x40 -> rindex=0x11, ghr=0x01.
REQ-035 Resolve pc=0x80, ghr=0x03, phr=2'b10, taken=1 -> next cycle pht_we_o=1, windex=0x23, taken=1, phr=2'b10; the following cycle pht_we_o=0.
REQ-036 Mispredict with resolve_ghr_i=0x05, taken=0, plus same-cycle pred_valid_i, taken=1 -> spec_ghr=0x0A; the prediction shift is discarded.
REQ-037 arch_ghr=0x0F, flush_i with same-cycle accepted resolve taken=1 and mispredict -> spec_ghr=0x1F (flush wins).
REQ-038 rst_n pulsed low at sweep index 0x80 -> outputs reset immediately; after release the sweep restarts at 0x00.
